// File: rtl/wr_arria10_rst_seq.sv
`default_nettype none
// ============================================================================
// Module   : wr_arria10_rst_seq
// Brief    : Reset sequencer in front of the Arria 10 transceiver reset
//            controller; qualifies tx/rx ready and reports link_up.
// Revision : 1.0 - initial release
// ============================================================================
module wr_arria10_rst_seq #(
    parameter int G_POR_CYCLES       = 1000,
    parameter int G_RST_PULSE_CYCLES = 16,
    parameter int G_TIMEOUT_CYCLES   = 1000000,
    parameter int G_LOCK_LOSS_FILTER = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rst_req_i,
    output logic       ctl_reset_o,
    input  logic       tx_ready_i,
    input  logic       rx_ready_i,
    input  logic       rx_is_lockedtodata_i,
    output logic       tx_ready_o,
    output logic       rx_ready_o,
    output logic       link_up_o,
    output logic [7:0] retry_cnt_o,
    output logic [2:0] state_o
);

    localparam int c_POR_W   = $clog2(G_POR_CYCLES + 1);
    localparam int c_PULSE_W = $clog2(G_RST_PULSE_CYCLES + 1);
    localparam int c_TMO_W   = $clog2(G_TIMEOUT_CYCLES + 1);
    localparam int c_FILT_W  = $clog2(G_LOCK_LOSS_FILTER + 1);

    localparam logic [c_POR_W-1:0]   c_POR_LAST   = c_POR_W'(G_POR_CYCLES - 1);
    localparam logic [c_PULSE_W-1:0] c_PULSE_LAST = c_PULSE_W'(G_RST_PULSE_CYCLES - 1);
    localparam logic [c_TMO_W-1:0]   c_TMO_LAST   = c_TMO_W'(G_TIMEOUT_CYCLES - 1);
    localparam logic [c_FILT_W-1:0]  c_FILT_LAST  = c_FILT_W'(G_LOCK_LOSS_FILTER - 1);

    localparam logic [c_POR_W-1:0]   c_POR_ONE   = c_POR_W'(1);
    localparam logic [c_PULSE_W-1:0] c_PULSE_ONE = c_PULSE_W'(1);
    localparam logic [c_TMO_W-1:0]   c_TMO_ONE   = c_TMO_W'(1);
    localparam logic [c_FILT_W-1:0]  c_FILT_ONE  = c_FILT_W'(1);

    typedef enum logic [2:0] {
        S_POR_WAIT   = 3'd0,
        S_ASSERT_RST = 3'd1,
        S_WAIT_TX    = 3'd2,
        S_WAIT_RX    = 3'd3,
        S_RUNNING    = 3'd4
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic [c_POR_W-1:0]   r_por_cnt;
    logic [c_PULSE_W-1:0] r_pulse_cnt;
    logic [c_TMO_W-1:0]   r_tmo_cnt;
    logic [c_FILT_W-1:0]  r_filt_cnt;
    logic [1:0]           r_lock_sync;
    logic [7:0]           r_retry;
    logic                 w_lock;
    logic                 w_fail;
    logic                 w_tmo_hit;
    logic                 w_filt_hit;
    logic                 w_in_wait;
    logic                 w_next_wait;

    assign w_lock      = r_lock_sync[1];
    assign w_tmo_hit   = (r_tmo_cnt == c_TMO_LAST);
    assign w_filt_hit  = !w_lock && (r_filt_cnt == c_FILT_LAST);
    assign w_in_wait   = (r_state == S_WAIT_TX) || (r_state == S_WAIT_RX);
    assign w_next_wait = (w_next == S_WAIT_TX) || (w_next == S_WAIT_RX);

    // A timeout wins over forward progress in the same cycle.
    always_comb begin
        w_next = r_state;
        w_fail = 1'b0;
        case (r_state)
            S_POR_WAIT: begin
                if (r_por_cnt == c_POR_LAST) w_next = S_ASSERT_RST;
            end
            S_ASSERT_RST: begin
                if (!rst_req_i && (r_pulse_cnt == c_PULSE_LAST)) w_next = S_WAIT_TX;
            end
            S_WAIT_TX: begin
                if (w_tmo_hit)       w_fail = 1'b1;
                else if (tx_ready_i) w_next = S_WAIT_RX;
            end
            S_WAIT_RX: begin
                if (w_tmo_hit || !tx_ready_i)   w_fail = 1'b1;
                else if (rx_ready_i && w_lock) w_next = S_RUNNING;
            end
            S_RUNNING: begin
                if (!tx_ready_i || !rx_ready_i || w_filt_hit) w_fail = 1'b1;
            end
            default: w_next = S_POR_WAIT;
        endcase
        if (w_fail) w_next = S_ASSERT_RST;
        // Software request overrides any failure and never counts as a retry.
        if (rst_req_i && (r_state != S_POR_WAIT)) begin
            w_next = S_ASSERT_RST;
            w_fail = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= S_POR_WAIT;
            r_por_cnt   <= '0;
            r_pulse_cnt <= '0;
            r_tmo_cnt   <= '0;
            r_filt_cnt  <= '0;
            r_lock_sync <= 2'b00;
            r_retry     <= 8'd0;
            ctl_reset_o <= 1'b1;
            tx_ready_o  <= 1'b0;
            rx_ready_o  <= 1'b0;
            link_up_o   <= 1'b0;
        end else begin
            r_lock_sync <= {r_lock_sync[0], rx_is_lockedtodata_i};
            r_state     <= w_next;

            if ((r_state == S_POR_WAIT) && (w_next == S_POR_WAIT))
                r_por_cnt <= r_por_cnt + c_POR_ONE;
            else
                r_por_cnt <= '0;

            if ((r_state == S_ASSERT_RST) && (w_next == S_ASSERT_RST) && !rst_req_i)
                r_pulse_cnt <= r_pulse_cnt + c_PULSE_ONE;
            else
                r_pulse_cnt <= '0;

            if (w_in_wait && w_next_wait)
                r_tmo_cnt <= r_tmo_cnt + c_TMO_ONE;
            else
                r_tmo_cnt <= '0;

            if ((r_state == S_RUNNING) && (w_next == S_RUNNING) && !w_lock)
                r_filt_cnt <= r_filt_cnt + c_FILT_ONE;
            else
                r_filt_cnt <= '0;

            if (w_fail && (r_retry != 8'hFF))
                r_retry <= r_retry + 8'd1;

            ctl_reset_o <= (w_next == S_POR_WAIT) || (w_next == S_ASSERT_RST);
            tx_ready_o  <= (w_next == S_WAIT_RX) || (w_next == S_RUNNING);
            rx_ready_o  <= (w_next == S_RUNNING);
            link_up_o   <= (w_next == S_RUNNING);
        end
    end

    assign retry_cnt_o = r_retry;
    assign state_o     = r_state;

endmodule
`default_nettype wire
